// File: rtl/rx_route_pkg.sv
// Shared types and header helpers for the receive routing node.
package rx_route_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StFwd  = 1'b1
    } rx_state_e;

    // Header layout: select field at the bottom, broadcast flag directly above it.
    localparam int unsigned HDR_SEL_LSB = 0;
    localparam int unsigned MAX_CH      = 64;

    function automatic logic [MAX_CH-1:0] onehot_sel(input logic [31:0] sel);
        logic [MAX_CH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (sel == 32'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/rx_route_slot.sv
// One-entry output register holding a beat with its last marker and target mask.
module rx_route_slot
    import rx_route_pkg::*;
#(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic [NUM_CH-1:0] i_mask,
    input  logic              i_fire,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic [NUM_CH-1:0] o_mask
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [NUM_CH-1:0] r_mask;

    // Load wins over fire so a simultaneous drain and refill keeps full throughput.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
            r_mask <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_last <= i_last;
            r_mask <= i_mask;
        end else if (i_fire) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_last = r_last;
    assign o_mask = r_mask;

endmodule

// File: rtl/rx_route_node.sv
// Packet router: header selects child port(s), payload forwarded via a one-beat slot
// and mirrored onto a tap port.
module rx_route_node
    import rx_route_pkg::*;
#(
    parameter int unsigned DATA_W   = 2,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned BCAST_EN = 0,
    parameter int unsigned TAP_EN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [NUM_CH-1:0] out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic [NUM_CH-1:0] out_ready,
    output logic              tap_valid,
    output logic [DATA_W-1:0] tap_data,
    input  logic              tap_ready,
    output logic              busy,
    output logic [15:0]       pkt_cnt
);

    localparam int unsigned SEL_W  = $clog2(NUM_CH);
    localparam logic        TAP_ON = (TAP_EN != 0);

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] w_mask_nxt;
    logic [15:0]       r_pkt_cnt;

    logic [SEL_W-1:0]  w_sel;
    logic              w_bcast;
    logic [NUM_CH-1:0] w_hdr_mask;
    logic              w_accept;
    logic              w_load;
    logic              w_fire;
    logic              w_in_ready;
    logic              w_slot_full;
    logic              w_slot_last;
    logic [DATA_W-1:0] w_slot_data;
    logic [NUM_CH-1:0] w_slot_mask;

    // Header decode
    assign w_sel = in_data[HDR_SEL_LSB +: SEL_W];

    if (BCAST_EN != 0) begin : g_bcast
        assign w_bcast = in_data[HDR_SEL_LSB + SEL_W];
    end else begin : g_no_bcast
        assign w_bcast = 1'b0;
    end

    assign w_hdr_mask = w_bcast ? {NUM_CH{1'b1}} : NUM_CH'(onehot_sel(32'(w_sel)));

    // A beat completes only when every targeted child and the tap (if enabled) take it.
    assign w_fire = w_slot_full
                  & (&(~w_slot_mask | out_ready))
                  & (tap_ready | ~TAP_ON);

    assign w_in_ready = (r_state == StIdle) | ~w_slot_full | w_fire;
    assign w_accept   = in_valid & w_in_ready;
    assign w_load     = w_accept & (r_state == StFwd);

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        unique case (r_state)
            StIdle: begin
                // Header-only packets (last set on the header) leave us in idle.
                if (w_accept && !in_last) begin
                    w_state_nxt = StFwd;
                    w_mask_nxt  = w_hdr_mask;
                end
            end
            StFwd: begin
                if (w_accept && in_last) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_mask    <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            if (w_fire && w_slot_last) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    rx_route_slot #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) u_slot (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (in_data),
        .i_last (in_last),
        .i_mask (r_mask),
        .i_fire (w_fire),
        .o_full (w_slot_full),
        .o_data (w_slot_data),
        .o_last (w_slot_last),
        .o_mask (w_slot_mask)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_slot_full ? w_slot_mask : '0;
    assign out_data  = w_slot_data;
    assign out_last  = w_slot_last;
    assign tap_valid = w_slot_full & TAP_ON;
    assign tap_data  = w_slot_data;
    assign busy      = (r_state != StIdle) | w_slot_full;
    assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_rx_route_node.sv
// Directed bench: a 4-child broadcast-capable node with tap, plus a 2-child node without tap.
module tb_rx_route_node;

    logic        clk;
    logic        rst;

    logic        a_in_valid;
    logic [3:0]  a_in_data;
    logic        a_in_last;
    logic        a_in_ready;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_data;
    logic        a_out_last;
    logic [3:0]  a_out_ready;
    logic        a_tap_valid;
    logic [3:0]  a_tap_data;
    logic        a_tap_ready;
    logic        a_busy;
    logic [15:0] a_pkt_cnt;

    logic        b_in_valid;
    logic [1:0]  b_in_data;
    logic        b_in_last;
    logic        b_in_ready;
    logic [1:0]  b_out_valid;
    logic [1:0]  b_out_data;
    logic        b_out_last;
    logic [1:0]  b_out_ready;
    logic        b_tap_valid;
    logic [1:0]  b_tap_data;
    logic        b_tap_ready;
    logic        b_busy;
    logic [15:0] b_pkt_cnt;

    int n_vec = 0;
    int n_err = 0;

    rx_route_node #(
        .DATA_W   (4),
        .NUM_CH   (4),
        .BCAST_EN (1),
        .TAP_EN   (1)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_last   (a_in_last),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .out_ready (a_out_ready),
        .tap_valid (a_tap_valid),
        .tap_data  (a_tap_data),
        .tap_ready (a_tap_ready),
        .busy      (a_busy),
        .pkt_cnt   (a_pkt_cnt)
    );

    rx_route_node #(
        .DATA_W   (2),
        .NUM_CH   (2),
        .BCAST_EN (0),
        .TAP_EN   (0)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .out_ready (b_out_ready),
        .tap_valid (b_tap_valid),
        .tap_data  (b_tap_data),
        .tap_ready (b_tap_ready),
        .busy      (b_busy),
        .pkt_cnt   (b_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [3:0] d, input logic l);
        a_in_valid = v;
        a_in_data  = d;
        a_in_last  = l;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0;
        a_out_ready = 4'hF; a_tap_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0;
        b_out_ready = 2'b11; b_tap_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid", 32'(a_out_valid), 32'h0);
        chk("rst_tap_valid", 32'(a_tap_valid), 32'h0);
        chk("rst_busy",      32'(a_busy),      32'h0);
        chk("rst_pkt_cnt",   32'(a_pkt_cnt),   32'h0);
        chk("rst_in_ready",  32'(a_in_ready),  32'h1);

        // Route to ch2: header 0x2, payload 0xA, 0xB(last)
        a_drive(1'b1, 4'h2, 1'b0);
        tick();
        chk("route_hdr_hidden", 32'(a_out_valid), 32'h0);
        chk("route_busy",       32'(a_busy),      32'h1);
        a_drive(1'b1, 4'hA, 1'b0);
        tick();
        chk("route_b0_valid", 32'(a_out_valid), 32'h4);
        chk("route_b0_data",  32'(a_out_data),  32'hA);
        chk("route_b0_tapv",  32'(a_tap_valid), 32'h1);
        chk("route_b0_tapd",  32'(a_tap_data),  32'hA);
        a_drive(1'b1, 4'hB, 1'b1);
        chk("route_thru_ready", 32'(a_in_ready), 32'h1);
        tick();
        chk("route_b1_valid", 32'(a_out_valid), 32'h4);
        chk("route_b1_data",  32'(a_out_data),  32'hB);
        chk("route_b1_last",  32'(a_out_last),  32'h1);
        chk("route_b1_tapd",  32'(a_tap_data),  32'hB);
        a_drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("route_drained", 32'(a_out_valid), 32'h0);
        chk("route_pkt_cnt", 32'(a_pkt_cnt),   32'h1);
        chk("route_idle",    32'(a_busy),      32'h0);

        // Backpressure on ch2 for 3 cycles
        a_drive(1'b1, 4'h2, 1'b0);
        tick();
        a_drive(1'b1, 4'h3, 1'b0);
        tick();
        a_out_ready = 4'b1011;
        a_drive(1'b1, 4'h4, 1'b0);
        chk("bp_in_ready_low", 32'(a_in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", 32'(a_out_valid), 32'h4);
            chk("bp_hold_data",  32'(a_out_data),  32'h3);
        end
        a_out_ready = 4'hF;
        #1;
        chk("bp_release_ready", 32'(a_in_ready), 32'h1);
        tick();
        chk("bp_next_data", 32'(a_out_data), 32'h4);
        a_drive(1'b1, 4'h5, 1'b1);
        tick();
        chk("bp_last_data", 32'(a_out_data), 32'h5);
        chk("bp_last_flag", 32'(a_out_last), 32'h1);
        a_drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("bp_pkt_cnt", 32'(a_pkt_cnt),   32'h2);
        chk("bp_drained", 32'(a_out_valid), 32'h0);

        // Tap gating: target ready but tap not ready
        a_drive(1'b1, 4'h1, 1'b0);
        tick();
        a_drive(1'b1, 4'h7, 1'b1);
        tick();
        a_tap_ready = 1'b0;
        a_drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("tap_block_valid", 32'(a_out_valid), 32'h2);
        chk("tap_block_cnt",   32'(a_pkt_cnt),   32'h2);
        a_tap_ready = 1'b1;
        tick();
        chk("tap_go_valid", 32'(a_out_valid), 32'h0);
        chk("tap_go_cnt",   32'(a_pkt_cnt),   32'h3);

        // Broadcast: header 0b0100 sets the flag above the 2-bit select
        a_drive(1'b1, 4'h4, 1'b0);
        tick();
        a_drive(1'b1, 4'h5, 1'b1);
        tick();
        a_out_ready = 4'b1110;
        a_drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("bc_valid_all", 32'(a_out_valid), 32'hF);
        chk("bc_partial",   32'(a_pkt_cnt),   32'h3);
        a_out_ready = 4'hF;
        tick();
        chk("bc_fired",     32'(a_out_valid), 32'h0);
        chk("bc_pkt_cnt",   32'(a_pkt_cnt),   32'h4);

        // Back-to-back: ch0 beat stays in the slot while ch1 header is consumed
        a_drive(1'b1, 4'h0, 1'b0);
        tick();
        a_drive(1'b1, 4'h6, 1'b1);
        tick();
        a_out_ready = 4'h0;
        a_drive(1'b1, 4'h1, 1'b0);
        chk("b2b_hdr_ready", 32'(a_in_ready), 32'h1);
        tick();
        chk("b2b_old_mask", 32'(a_out_valid), 32'h1);
        chk("b2b_old_data", 32'(a_out_data),  32'h6);
        a_out_ready = 4'hF;
        a_drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("b2b_cnt_a", 32'(a_pkt_cnt), 32'h5);
        a_drive(1'b1, 4'h9, 1'b1);
        tick();
        chk("b2b_new_mask", 32'(a_out_valid), 32'h2);
        chk("b2b_new_data", 32'(a_out_data),  32'h9);
        a_drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("b2b_cnt_b", 32'(a_pkt_cnt), 32'h6);
        // Header-only packet
        a_drive(1'b1, 4'h3, 1'b1);
        tick();
        a_drive(1'b0, 4'h0, 1'b0);
        chk("empty_no_out",  32'(a_out_valid), 32'h0);
        chk("empty_idle",    32'(a_busy),      32'h0);
        tick();
        chk("empty_no_out2", 32'(a_out_valid), 32'h0);
        chk("empty_cnt",     32'(a_pkt_cnt),   32'h6);

        // Reset mid-packet
        a_drive(1'b1, 4'h2, 1'b0);
        tick();
        a_drive(1'b1, 4'h1, 1'b0);
        tick();
        a_drive(1'b1, 4'h2, 1'b0);
        tick();
        chk("mid_pre_valid", 32'(a_out_valid), 32'h4);
        rst = 1'b1;
        a_drive(1'b0, 4'h0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_out_valid), 32'h0);
        chk("mid_rst_tap",   32'(a_tap_valid), 32'h0);
        chk("mid_rst_cnt",   32'(a_pkt_cnt),   32'h0);
        chk("mid_rst_busy",  32'(a_busy),      32'h0);
        a_drive(1'b1, 4'h1, 1'b0);
        tick();
        chk("mid_hdr_hidden", 32'(a_out_valid), 32'h0);
        a_drive(1'b1, 4'hC, 1'b1);
        tick();
        chk("mid_new_mask", 32'(a_out_valid), 32'h2);
        chk("mid_new_data", 32'(a_out_data),  32'hC);
        a_drive(1'b0, 4'h0, 1'b0);
        tick();
        chk("mid_new_cnt", 32'(a_pkt_cnt), 32'h1);

        // Tap disabled: fires regardless of tap_ready
        b_tap_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 2'h1; b_in_last = 1'b0;
        tick();
        b_in_data = 2'h2; b_in_last = 1'b1;
        tick();
        b_in_valid = 1'b0;
        #1;
        chk("notap_valid",  32'(b_out_valid), 32'h2);
        chk("notap_data",   32'(b_out_data),  32'h2);
        chk("notap_tapv",   32'(b_tap_valid), 32'h0);
        chk("notap_tapd",   32'(b_tap_data),  32'h2);
        tick();
        chk("notap_fired",  32'(b_out_valid), 32'h0);
        chk("notap_cnt",    32'(b_pkt_cnt),   32'h1);
        chk("notap_busy",   32'(b_busy),      32'h0);
        chk("notap_ready",  32'(b_in_ready),  32'h1);
        chk("notap_last",   32'(b_out_last),  32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_route_node.md
Name: rx_route_node

Overview:
- Clocked, parametrised successor of the two-child receive routing node in the tree fabric.
- Accepts a packet stream and uses the first beat (header) to pick one of NUM_CH children, or all children when broadcast is enabled.
- Strips the header and forwards payload beats through a one-entry output register.
- Mirrors every forwarded beat onto a tap port; a beat completes only when every target and the tap accept it.

Parameters:
- DATA_W, 2, beat width; must be >= SEL_W + BCAST_EN.
- NUM_CH, 2, number of child ports; power of two, >= 2.
- SEL_W, $clog2(NUM_CH), header select field width (derived, not overridden).
- BCAST_EN, 0, 1 = header bit SEL_W requests broadcast to all children.
- TAP_EN, 1, 1 = tap port participates in the handshake; 0 = tap_ready ignored.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_data  in  DATA_W  upstream beat.
- in_last  in  1  final beat of packet.
- in_ready  out  1  upstream beat accepted when in_valid & in_ready.
- out_valid  out  NUM_CH  per-child valid.
- out_data  out  DATA_W  shared child data bus.
- out_last  out  1  shared last marker.
- out_ready  in  NUM_CH  per-child ready.
- tap_valid  out  1  tap copy valid.
- tap_data  out  DATA_W  tap copy of out_data.
- tap_ready  in  1  tap ready.
- busy  out  1  high while not in IDLE or output slot occupied.
- pkt_cnt  out  16  completed forwarded packets, wraps at 0xFFFF->0.

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE, slot empty, target mask 0, pkt_cnt 0; all out_valid, tap_valid and busy 0. in_ready is 1 in the cycle after reset.
- Reset mid-packet discards the partial packet and any slot content. The first beat after reset is a header.
- States:
  - IDLE: in_ready=1. An accepted beat is the header and is consumed, never forwarded.
  - Header decode: sel = in_data[SEL_W-1:0]. If BCAST_EN and in_data[SEL_W], target mask = all ones; otherwise target mask = onehot(sel).
  - Header with in_last=1: empty packet. Stay IDLE, nothing emitted, pkt_cnt unchanged.
  - Header with in_last=0: go to FWD, target mask latched.
  - FWD: in_ready = ~slot_full | fire.
  - Each accepted beat loads the slot (data, last) at the next edge, so latency is 1 cycle from acceptance to out_valid.
  - Accepted beat with in_last=1: return to IDLE on the same edge. A new header may be accepted the following cycle while the slot still drains.
- Slot outputs:
  - out_valid = slot_full ? mask : 0.
  - tap_valid = slot_full & TAP_EN.
  - tap_data = out_data.
- fire = slot_full & all targeted out_ready & (tap_ready | ~TAP_EN). Non-targeted readies are ignored.
- Beats complete atomically: a partially ready target set does not fire. Valid, data and mask hold stable until fire; valid must not depend on ready.
- Slot mask is captured per beat. A drained tail of packet A keeps A's mask even after packet B's header is accepted.
- fire with slot last=1 increments pkt_cnt by 1, modulo 2^16.
- Simultaneous fire and new accept: slot reloads the same cycle, giving full throughput of 1 beat/cycle.
- in_data and in_last are don't-care when in_valid=0.

Decomposition:
- Package rx_route_pkg: state enum (IDLE, FWD), header field offsets, function onehot_sel.
- Sub-module rx_route_slot: one-entry register with data, last and mask, a load/fire handshake, and slot_full.
- The top level holds the FSM, header decode, fire reduction and counter.

Test Plan:
- Route (NUM_CH=4, TAP_EN=1): header 0x2, payload 0xA, 0xB (last), all ready -> out_valid=4'b0100 for 2 cycles with data 0xA then 0xB; header never appears; tap mirrors both beats; pkt_cnt=1.
- Backpressure: out_ready[2]=0 for 3 cycles mid-packet -> beat held stable, no fire, in_ready=0 once slot full; releases within 1 cycle of ready; no beat lost or duplicated.
- Tap gating: tap_ready=0 with target ready -> no fire. Repeat with TAP_EN=0 -> fires regardless of tap_ready.
- Broadcast (BCAST_EN=1, NUM_CH=4, DATA_W=3): header 0b100, payload 0x5 (last) -> out_valid=4'hF. out_ready=4'b1110 gives no fire; 4'hF fires once.
- Back-to-back: packet to ch0 (1 payload) immediately followed by header ch1 -> the ch0 beat keeps mask 0001 while the ch1 header is consumed. Then a header-only packet with in_last=1 -> nothing emitted, pkt_cnt +0.
- Reset mid-packet: rst=1 for 1 cycle after the 2nd payload beat -> all valids 0, pkt_cnt=0. The next in beat 0x1 is treated as header to ch1.
